// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner: FSM states, default
// geometry/timing, code width and lowest-set-bit index.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EVAL = 2'd2
   } scan_state_t;

   localparam int DEF_ROWS           = 4;
   localparam int DEF_COLS           = 4;
   localparam int DEF_SCAN_DIV       = 50000;
   localparam int DEF_DEBOUNCE_SCANS = 4;

   // Widest matrix the priority encoder handles (ROWS*COLS must not exceed this).
   localparam int MAX_KEYS = 64;

   function automatic int code_width(input int n_keys);
      return (n_keys > 1) ? $clog2(n_keys) : 1;
   endfunction

   function automatic int lowest_set(input logic [MAX_KEYS-1:0] v);
      int idx;
      idx = 0;
      for (int i = MAX_KEYS - 1; i >= 0; i--) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous inputs.
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-by-row keypad matrix scanner with whole-frame debounce and press reporting.
//
//   state | meaning
//   IDLE  | one cycle after reset, all rows released
//   SCAN  | one row driven low; columns sampled on the last dwell cycle
//   EVAL  | one cycle, all rows released; frame compared and debounced
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int   ROWS           = DEF_ROWS,
   parameter int   COLS           = DEF_COLS,
   parameter int   SCAN_DIV       = DEF_SCAN_DIV,
   parameter int   DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
   localparam int  N_KEYS         = ROWS * COLS,
   localparam int  CODE_W         = code_width(ROWS * COLS)
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [COLS-1:0]   Col_In,
   output logic [ROWS-1:0]   Row_Out,
   output logic              Key_Valid,
   output logic [CODE_W-1:0] Key_Code,
   output logic              Key_Held,
   output logic              Multi_Key
);

   localparam int               DIV_W    = $clog2(SCAN_DIV);
   localparam int               ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_SCANS);

   scan_state_t         state, state_nxt;
   logic [DIV_W-1:0]    div_q, div_nxt;
   logic [ROW_W-1:0]    row_q, row_nxt;
   logic [ROWS-1:0]     row_out_nxt;
   logic [N_KEYS-1:0]   frame_q, frame_nxt;
   logic [N_KEYS-1:0]   prev_frame_q, prev_frame_nxt;
   logic [N_KEYS-1:0]   deb_q, deb_nxt, deb_d_q;
   logic [3:0]          stable_q, stable_nxt;
   logic [COLS-1:0]     col_sync, col_pressed;
   logic [MAX_KEYS-1:0] deb_pad;

   // Idle column pins read high through the pull-ups, so reset the synchronizer high.
   sync_2ff #(
      .WIDTH     (COLS),
      .RESET_VAL ({COLS{1'b1}})
   ) u_col_sync (
      .clk   (Clk),
      .rst_n (Reset_n),
      .d     (Col_In),
      .q     (col_sync)
   );

   assign col_pressed = ~col_sync;
   assign deb_pad     = MAX_KEYS'(deb_q);

   function automatic logic [ROWS-1:0] row_drive(input logic [ROW_W-1:0] r);
      return ~(ROWS'(1) << r);
   endfunction

   always_comb begin
      state_nxt      = state;
      div_nxt        = div_q;
      row_nxt        = row_q;
      row_out_nxt    = '1;
      frame_nxt      = frame_q;
      prev_frame_nxt = prev_frame_q;
      stable_nxt     = stable_q;
      deb_nxt        = deb_q;
      case (state)
         IDLE: begin
            state_nxt   = SCAN;
            row_nxt     = '0;
            div_nxt     = '0;
            row_out_nxt = row_drive('0);
         end
         SCAN: begin
            row_out_nxt = row_drive(row_q);
            if (div_q == DIV_LAST) begin
               frame_nxt[int'(row_q) * COLS +: COLS] = col_pressed;
               div_nxt = '0;
               if (row_q == ROW_LAST) begin
                  state_nxt   = EVAL;
                  row_out_nxt = '1;
               end else begin
                  row_nxt     = row_q + 1'b1;
                  row_out_nxt = row_drive(row_q + 1'b1);
               end
            end else begin
               div_nxt = div_q + 1'b1;
            end
         end
         EVAL: begin
            if (frame_q == prev_frame_q)
               stable_nxt = (stable_q >= DEB_N) ? DEB_N : stable_q + 1'b1;
            else
               stable_nxt = 4'd1;
            prev_frame_nxt = frame_q;
            if (stable_nxt == DEB_N && frame_q != deb_q)
               deb_nxt = frame_q;
            state_nxt   = SCAN;
            row_nxt     = '0;
            div_nxt     = '0;
            row_out_nxt = row_drive('0);
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= IDLE;
         div_q        <= '0;
         row_q        <= '0;
         Row_Out      <= '1;
         frame_q      <= '0;
         prev_frame_q <= '0;
         stable_q     <= '0;
         deb_q        <= '0;
      end else begin
         state        <= state_nxt;
         div_q        <= div_nxt;
         row_q        <= row_nxt;
         Row_Out      <= row_out_nxt;
         frame_q      <= frame_nxt;
         prev_frame_q <= prev_frame_nxt;
         stable_q     <= stable_nxt;
         deb_q        <= deb_nxt;
      end
   end

   // Key outputs follow the debounced state one cycle later; deb_d_q spots the 0 -> nonzero edge.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         deb_d_q   <= '0;
         Key_Valid <= 1'b0;
         Key_Code  <= '0;
         Key_Held  <= 1'b0;
         Multi_Key <= 1'b0;
      end else begin
         deb_d_q   <= deb_q;
         Key_Held  <= |deb_q;
         Multi_Key <= ($countones(deb_q) > 1);
         Key_Valid <= (deb_d_q == '0) && (deb_q != '0);
         if ((deb_d_q == '0) && (deb_q != '0))
            Key_Code <= CODE_W'(lowest_set(deb_pad));
      end
   end

endmodule
